// File: rtl/imem_responder.sv
// Read-only backing instruction memory answering icache fill requests.
// One request in flight at a time; single-cycle valid pulse after LATENCY cycles.
module imem_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORD_SIZE  = 4,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned LATENCY    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_BASE = DATA_WIDTH'(32'hA000_0000),
    parameter logic [DATA_WIDTH-1:0] ERR_DATA  = DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_instr,
    output logic                  mem_instr_valid,
    output logic                  mem_err,
    output logic                  busy,
    output logic [15:0]           req_count
);

    localparam int unsigned OFF_W = $clog2(WORD_SIZE);
    localparam int unsigned IDX_W = $clog2(NUM_WORDS);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] instr_next;
    logic                  valid_next;
    logic                  err_next;
    logic                  busy_next;
    logic [15:0]           count_next;

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  bad_access;
    logic [DATA_WIDTH-1:0] rdata;

    // Contents are fixed after reset; reset reloads the ramp pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned j = 0; j < NUM_WORDS; j++) begin
                mem[j] <= INIT_BASE + DATA_WIDTH'(j);
            end
        end
    end

    // Full-width word index for the range check, so high address bits never alias.
    assign word_addr    = addr_q >> OFF_W;
    assign misaligned   = (addr_q & ADDR_WIDTH'(WORD_SIZE - 1)) != '0;
    assign out_of_range = word_addr >= ADDR_WIDTH'(NUM_WORDS);
    assign bad_access   = misaligned || out_of_range;
    assign rdata        = mem[word_addr[IDX_W-1:0]];

    // Next-state and next-output logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        addr_next  = addr_q;
        instr_next = mem_instr;
        valid_next = 1'b0;
        err_next   = 1'b0;
        busy_next  = busy;
        count_next = req_count;

        case (state)
            IDLE: begin
                if (mem_req) begin
                    addr_next  = mem_addr;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    count_next = req_count + 16'd1;
                    busy_next  = 1'b1;
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                valid_next = 1'b1;
                err_next   = bad_access;
                instr_next = bad_access ? ERR_DATA : rdata;
                state_next = DRAIN;
            end
            DRAIN: begin
                // One dead cycle swallows a requester that drops mem_req late.
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            addr_q          <= '0;
            mem_instr       <= '0;
            mem_instr_valid <= 1'b0;
            mem_err         <= 1'b0;
            busy            <= 1'b0;
            req_count       <= '0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            addr_q          <= addr_next;
            mem_instr       <= instr_next;
            mem_instr_valid <= valid_next;
            mem_err         <= err_next;
            busy            <= busy_next;
            req_count       <= count_next;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance at LATENCY=1 and one at LATENCY=4
// sharing clock and reset.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        req1, req4;
    logic [31:0] addr1, addr4;
    logic [31:0] instr1, instr4;
    logic        valid1, valid4, err1, err4, busy1, busy4;
    logic [15:0] cnt1, cnt4;

    logic [15:0] exp_cnt1, exp_cnt4;
    int          checks;
    int          errors;

    imem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .mem_req(req1), .mem_addr(addr1),
        .mem_instr(instr1), .mem_instr_valid(valid1), .mem_err(err1),
        .busy(busy1), .req_count(cnt1)
    );

    imem_responder #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .mem_req(req4), .mem_addr(addr4),
        .mem_instr(instr4), .mem_instr_valid(valid4), .mem_err(err4),
        .busy(busy4), .req_count(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and observe the response; comparisons are made by callers.
    task automatic run_req(input int sel, input logic [31:0] a,
                           output int lat, output logic [31:0] data, output logic err,
                           output int width, output int bcyc);
        logic v, b;
        lat = -1; width = 0; bcyc = 0; data = '0; err = 1'b0;
        if (sel == 1) begin
            req1 = 1'b1; addr1 = a; exp_cnt1 = exp_cnt1 + 16'd1;
        end else begin
            req4 = 1'b1; addr4 = a; exp_cnt4 = exp_cnt4 + 16'd1;
        end
        tick();
        req1 = 1'b0;
        req4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            v = (sel == 1) ? valid1 : valid4;
            b = (sel == 1) ? busy1 : busy4;
            if (b) bcyc++;
            if (v) begin
                if (lat < 0) begin
                    lat  = i;
                    data = (sel == 1) ? instr1 : instr4;
                    err  = (sel == 1) ? err1 : err4;
                end
                width++;
            end else if (lat >= 0 && !b) begin
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int lat, width, bcyc;
        logic [31:0] d;
        logic e;
        rst = 1'b1;
        repeat (10) tick();
        rst = 1'b0;
        exp_cnt1 = '0;
        exp_cnt4 = '0;
        checks++; if ({valid1, err1, busy1} !== 3'b000) begin errors++; $display("FAIL reset_flags_l1 got %b want 000", {valid1, err1, busy1}); end
        checks++; if (instr1 !== 32'h0 || cnt1 !== 16'h0) begin errors++; $display("FAIL reset_data_l1 instr=%h cnt=%h want 0/0", instr1, cnt1); end
        checks++; if ({valid4, err4, busy4} !== 3'b000 || instr4 !== 32'h0 || cnt4 !== 16'h0) begin errors++; $display("FAIL reset_l4 v/e/b=%b instr=%h cnt=%h want zeros", {valid4, err4, busy4}, instr4, cnt4); end
        tick();
        run_req(1, 32'h0, lat, d, e, width, bcyc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL first_req_latency got %0d want 1", lat); end
        checks++; if (d !== 32'hA000_0000 || e !== 1'b0) begin errors++; $display("FAIL first_req_data got %h err=%b want a0000000 err=0", d, e); end
    endtask

    task automatic test_latency();
        int lat, width, bcyc;
        logic [31:0] d;
        logic e;
        run_req(1, 32'h0000_0FFC, lat, d, e, width, bcyc);
        checks++; if (lat !== 1 || width !== 1) begin errors++; $display("FAIL lat1_timing lat=%0d width=%0d want 1/1", lat, width); end
        checks++; if (d !== 32'hA000_03FF || e !== 1'b0) begin errors++; $display("FAIL lat1_data got %h err=%b want a00003ff err=0", d, e); end
        checks++; if (bcyc !== 2) begin errors++; $display("FAIL lat1_busy got %0d want 2", bcyc); end
        run_req(4, 32'h0000_0FFC, lat, d, e, width, bcyc);
        checks++; if (lat !== 4 || width !== 1) begin errors++; $display("FAIL lat4_timing lat=%0d width=%0d want 4/1", lat, width); end
        checks++; if (d !== 32'hA000_03FF || e !== 1'b0) begin errors++; $display("FAIL lat4_data got %h err=%b want a00003ff err=0", d, e); end
        checks++; if (bcyc !== 5) begin errors++; $display("FAIL lat4_busy got %0d want 5", bcyc); end
        checks++; if (cnt4 !== exp_cnt4) begin errors++; $display("FAIL lat4_count got %0d want %0d", cnt4, exp_cnt4); end
    endtask

    task automatic test_back_to_back();
        int last, pulses;
        last = -1;
        pulses = 0;
        req1 = 1'b1;
        addr1 = 32'h10;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid1) begin
                pulses++;
                checks++; if (instr1 !== 32'hA000_0004 || err1 !== 1'b0) begin errors++; $display("FAIL held_data got %h err=%b want a0000004 err=0", instr1, err1); end
                if (last >= 0) begin
                    checks++; if (i - last !== 3) begin errors++; $display("FAIL held_spacing got %0d want 3", i - last); end
                end
                last = i;
            end
        end
        req1 = 1'b0;
        exp_cnt1 = exp_cnt1 + 16'd7;
        repeat (3) tick();
        checks++; if (pulses !== 7) begin errors++; $display("FAIL held_pulses got %0d want 7", pulses); end
        checks++; if (cnt1 !== exp_cnt1) begin errors++; $display("FAIL held_count got %0d want %0d", cnt1, exp_cnt1); end
    endtask

    task automatic test_errors();
        int lat, width, bcyc;
        logic [31:0] d;
        logic e;
        run_req(1, 32'h0000_1000, lat, d, e, width, bcyc);
        checks++; if (lat !== 1 || width !== 1) begin errors++; $display("FAIL oob_timing lat=%0d width=%0d want 1/1", lat, width); end
        checks++; if (d !== 32'hDEAD_BEEF || e !== 1'b1) begin errors++; $display("FAIL oob_resp got %h err=%b want deadbeef err=1", d, e); end
        run_req(1, 32'h0000_0006, lat, d, e, width, bcyc);
        checks++; if (lat !== 1 || d !== 32'hDEAD_BEEF || e !== 1'b1) begin errors++; $display("FAIL misaligned lat=%0d data=%h err=%b want 1/deadbeef/1", lat, d, e); end
        run_req(1, 32'h8000_0000, lat, d, e, width, bcyc);
        checks++; if (d !== 32'hDEAD_BEEF || e !== 1'b1) begin errors++; $display("FAIL high_alias got %h err=%b want deadbeef err=1", d, e); end
        run_req(4, 32'h0000_1000, lat, d, e, width, bcyc);
        checks++; if (lat !== 4 || d !== 32'hDEAD_BEEF || e !== 1'b1) begin errors++; $display("FAIL oob_lat4 lat=%0d data=%h err=%b want 4/deadbeef/1", lat, d, e); end
        run_req(1, 32'h0000_0008, lat, d, e, width, bcyc);
        checks++; if (d !== 32'hA000_0002 || e !== 1'b0) begin errors++; $display("FAIL after_err got %h err=%b want a0000002 err=0", d, e); end
        checks++; if (cnt1 !== exp_cnt1) begin errors++; $display("FAIL err_count got %0d want %0d", cnt1, exp_cnt1); end
    endtask

    task automatic test_mid_reset();
        int lat, width, bcyc, seen;
        logic [31:0] d;
        logic e;
        req4 = 1'b1;
        addr4 = 32'h20;
        tick();
        req4 = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_cnt1 = '0;
        exp_cnt4 = '0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid4) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_pulse got %0d pulses want 0", seen); end
        checks++; if (cnt4 !== 16'h0 || busy4 !== 1'b0) begin errors++; $display("FAIL midreset_state cnt=%0d busy=%b want 0/0", cnt4, busy4); end
        run_req(4, 32'h8, lat, d, e, width, bcyc);
        checks++; if (lat !== 4 || d !== 32'hA000_0002 || e !== 1'b0) begin errors++; $display("FAIL midreset_next lat=%0d data=%h err=%b want 4/a0000002/0", lat, d, e); end
        checks++; if (cnt4 !== exp_cnt4) begin errors++; $display("FAIL midreset_count got %0d want %0d", cnt4, exp_cnt4); end
    endtask

    task automatic test_soak();
        int lat, width, bcyc;
        int unsigned idx;
        logic [31:0] d;
        logic e;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_cnt1 = '0;
        exp_cnt4 = '0;
        for (int n = 0; n < 500; n++) begin
            idx = $urandom_range(0, 1023);
            run_req(1, idx << 2, lat, d, e, width, bcyc);
            checks++;
            if (lat !== 1 || d !== 32'hA000_0000 + idx || e !== 1'b0) begin
                errors++;
                $display("FAIL soak idx=%0d lat=%0d data=%h err=%b want 1/%h/0", idx, lat, d, e, 32'hA000_0000 + idx);
            end
        end
        checks++; if (cnt1 !== 16'd500 || cnt1 !== exp_cnt1) begin errors++; $display("FAIL soak_count got %0d want 500", cnt1); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        req1 = 1'b0;
        req4 = 1'b0;
        addr1 = '0;
        addr4 = '0;
        exp_cnt1 = '0;
        exp_cnt4 = '0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_errors();
        test_mid_reset();
        test_soak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Synthesizable backing instruction memory. It is the responder end of the icache miss interface (mem_req / mem_addr → mem_instr / mem_instr_valid).
- It accepts one fill request at a time, waits a programmable latency, then returns one word with a single-cycle valid pulse.
- It sits below icache_fifo in the fetch path and replaces the behavioural memory model in system-level simulation.

Parameters:
- ADDR_WIDTH, 32, request address width in bits.
- DATA_WIDTH, 32, word width in bits.
- WORD_SIZE, 4, bytes per word. Power of two.
- NUM_WORDS, 1024, memory depth in words. Power of two.
- LATENCY, 1, cycles from request acceptance to the valid pulse. Legal range 1..15.
- INIT_BASE, 32'hA000_0000, reset content: word j = INIT_BASE + j.
- ERR_DATA, 32'hDEAD_BEEF, data returned for an out-of-range address.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous, active-high reset.
- mem_req, input, 1, fill request from the cache. Level-sensitive.
- mem_addr, input, ADDR_WIDTH, byte address of the requested word.
- mem_instr, output, DATA_WIDTH, returned word. Meaningful only while mem_instr_valid=1.
- mem_instr_valid, output, 1, one-cycle response strobe.
- mem_err, output, 1, qualifies mem_instr_valid: the request was out of range or misaligned.
- busy, output, 1, high from acceptance through the DRAIN cycle.
- req_count, output, 16, number of accepted requests. Wraps modulo 2^16.

Behaviour:
- Array: NUM_WORDS x DATA_WIDTH registers. Contents are loaded on reset: word j = INIT_BASE + j, truncated to DATA_WIDTH.
- Reset (asynchronous assert, synchronous deassert by the first clock edge):
  - State = IDLE.
  - mem_instr = 0, mem_instr_valid = 0, mem_err = 0, busy = 0, req_count = 0, latency counter = 0.
  - The array is reinitialised.
  - Reset mid-transaction abandons the request; no valid pulse is produced afterwards.
- States: IDLE, WAIT, RESP, DRAIN.
- IDLE:
  - If mem_req=1 at an edge: capture mem_addr, load the counter with LATENCY-1, req_count+1, busy=1.
  - Next state is RESP when LATENCY=1, otherwise WAIT.
- WAIT:
  - Decrement the counter each edge.
  - When the counter reaches 0, go to RESP.
  - mem_req and mem_addr are ignored; changes are not re-sampled.
- RESP (entered on the edge that registers the outputs):
  - mem_instr_valid=1 for exactly one cycle.
  - mem_instr = array[captured_addr >> log2(WORD_SIZE)].
  - mem_err=0 on a good access.
  - Next state is DRAIN.
- DRAIN:
  - mem_instr_valid=0 and mem_err=0. mem_instr holds its last value.
  - busy stays 1. mem_req is ignored this cycle, which absorbs a requester that drops mem_req one cycle late.
  - Next state is IDLE, with busy=0.
- Timing: request sampled at edge k → valid is high during the cycle after edge k+LATENCY.
- Back-to-back: minimum spacing between accepted requests is LATENCY+2 edges.
- Error path: if captured_addr[log2(WORD_SIZE)-1:0] != 0, or (captured_addr >> log2(WORD_SIZE)) >= NUM_WORDS:
  - mem_instr = ERR_DATA and mem_err=1 alongside valid.
  - Timing is identical to a normal access.
  - The array is not indexed.
- Word index: uses the full shifted address for the range check. There is no modulo aliasing.
- mem_req held high continuously: re-accepted on the first IDLE edge after DRAIN. Each acceptance produces exactly one valid pulse.
- req_count: increments only on acceptance. Wraps from 16'hFFFF to 0.
- The block is read-only; there is no write port.

Test Plan:
- Reset: hold rst 10 cycles, release → all outputs 0, state IDLE. Then a request to mem_addr=0x0 → valid 1 cycle later, mem_instr=0xA000_0000, mem_err=0.
- Latency: LATENCY=1, request at 0x0000_0FFC → valid pulse exactly 1 cycle wide, data 0xA000_03FF. Repeat with LATENCY=4 → valid 4 cycles after acceptance, busy high for 5 cycles.
- Held request: mem_req stuck high for 20 cycles, addr 0x10, LATENCY=1 → a valid pulse every 3 cycles, each with 0xA000_0004. req_count increments per pulse.
- Errors: addr 0x0000_1000 (index 1024) → mem_instr=0xDEAD_BEEF, mem_err=1, same timing. Addr 0x0000_0006 (misaligned) → same error response.
- Mid-transaction reset: LATENCY=4, assert rst 2 cycles after acceptance → no valid pulse appears, req_count=0, next request serviced normally.
- Soak: 500 random aligned requests in range, scoreboard against INIT_BASE+index → zero mismatches, req_count=500.
